// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// One partial product or quotient bit per cycle; signs are fixed up in a final pass.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] move_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   counter;
  logic               op_div, zero_div, neg_q, neg_r;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;

  // op[0] clear selects the signed variants (MULT, DIV).
  logic             op_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_data[WIDTH-1];
  assign rt_neg    = op_signed & rt_data[WIDTH-1];
  assign rs_abs    = rs_neg ? -rs_data : rs_data;
  assign rt_abs    = rt_neg ? -rt_data : rt_data;

  // Multiply: add into the upper half, then shift the whole accumulator right.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  assign mul_addend = b_mag[0] ? a_mag : '0;
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], a_mag[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_diff  = div_shift - {1'b0, b_mag};

  // A zero divisor leaves remainder = |rs| and quotient = all ones naturally.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = zero_div ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (counter == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      counter     <= '0;
      acc         <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      op_div      <= 1'b0;
      zero_div    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div   <= op[1];
            zero_div <= op[1] & (rt_data == '0);
            a_mag    <= rs_abs;
            b_mag    <= rt_abs;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            acc      <= '0;
            counter  <= '0;
          end else begin
            if (mthi) hi <= move_data;
            if (mtlo) lo <= move_data;
          end
        end
        RUN: begin
          counter <= counter + CNT_W'(1);
          if (op_div) begin
            a_mag <= a_mag << 1;
            acc   <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};
          end else begin
            b_mag <= b_mag >> 1;
            acc   <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
